// File: rtl/riscv_regfile_mp.sv
// riscv_regfile_mp
// Multi-ported integer register file for the RISC-V core.
//   - NREAD combinational read ports, two write ports (port 1 wins on conflict)
//   - optional same-cycle write-to-read bypass (BYPASS=1)
//   - sequential clear engine: after reset, entries 1..NREGS-1 are zeroed one
//     per cycle, then ready_out rises
//   - debug read port for the on-board monitor; it always shows stored data
//
// Ports
//   clk_in        : clock, all state changes on the rising edge
//   rst_n_in      : synchronous active-low reset
//   we_in[1:0]    : write enable per write port
//   wa_in         : write addresses, port p at [p*AW +: AW]
//   wd_in         : write data, port p at [p*XLEN +: XLEN]
//   ra_in         : read addresses, port r at [r*AW +: AW]
//   rd_out        : read data, port r at [r*XLEN +: XLEN] (combinational)
//   dbg_addr_in   : debug read address
//   dbg_data_out  : debug read data (combinational, never bypassed)
//   ready_out     : clear sequence finished; writes are accepted only while high
//   drop_out      : one-cycle pulse after an enabled nonzero-address write was
//                   discarded because the clear sequence was still running
//
// ready_out is a level, not a handshake: the writeback stage does not stall on
// it; writes issued while it is low are discarded and reported via drop_out.
module riscv_regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [1:0]            we_in,
  input  logic [2*AW-1:0]       wa_in,
  input  logic [2*XLEN-1:0]     wd_in,
  input  logic [NREAD*AW-1:0]   ra_in,
  output logic [NREAD*XLEN-1:0] rd_out,
  input  logic [AW-1:0]         dbg_addr_in,
  output logic [XLEN-1:0]       dbg_data_out,
  output logic                  ready_out,
  output logic                  drop_out
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_ptr;
  logic            r_ready;
  logic            r_drop;
  logic [XLEN-1:0] r_mem [NREGS];

  logic [AW-1:0]   w_wa0;
  logic [AW-1:0]   w_wa1;
  logic [XLEN-1:0] w_wd0;
  logic [XLEN-1:0] w_wd1;
  logic            w_wen0;
  logic            w_wen1;
  logic            w_is_ready;

  assign w_wa0 = wa_in[0  +: AW];
  assign w_wa1 = wa_in[AW +: AW];
  assign w_wd0 = wd_in[0    +: XLEN];
  assign w_wd1 = wd_in[XLEN +: XLEN];

  // A write to x0 is not a real write: it neither stores, bypasses nor
  // counts as a dropped write.
  assign w_wen0 = we_in[0] && (w_wa0 != '0);
  assign w_wen1 = we_in[1] && (w_wa1 != '0);

  assign w_is_ready = (r_state == ST_READY);

  // Clear FSM. Entry 0 is never stored, so the sweep starts at 1.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= ST_CLEAR;
      r_ptr   <= AW'(1);
      r_ready <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_drop <= w_wen0 | w_wen1;
          if (r_ptr == AW'(NREGS - 1)) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end else begin
            r_ptr <= r_ptr + AW'(1);
          end
        end
        ST_READY: begin
          r_drop <= 1'b0;
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ready <= 1'b0;
          r_drop  <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset: contents survive the reset edge and are zeroed by
  // the sweep. Port 1 is written last so it wins an address conflict.
  always_ff @(posedge clk_in) begin
    if (rst_n_in) begin
      if (!w_is_ready) begin
        r_mem[r_ptr] <= '0;
      end else begin
        if (w_wen0) r_mem[w_wa0] <= w_wd0;
        if (w_wen1) r_mem[w_wa1] <= w_wd1;
      end
    end
  end

  // Read ports. While clearing, stale contents must not leak, so all ports
  // return zero until the sweep has finished.
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit0;
    logic          w_hit1;

    assign w_ra   = ra_in[g*AW +: AW];
    assign w_hit0 = (BYPASS != 0) && w_wen0 && (w_wa0 == w_ra);
    assign w_hit1 = (BYPASS != 0) && w_wen1 && (w_wa1 == w_ra);

    assign rd_out[g*XLEN +: XLEN] =
      (!w_is_ready || (w_ra == '0)) ? '0    :
      w_hit1                        ? w_wd1 :
      w_hit0                        ? w_wd0 :
                                      r_mem[w_ra];
  end

  assign dbg_data_out = (w_is_ready && (dbg_addr_in != '0)) ? r_mem[dbg_addr_in] : '0;

  assign ready_out = r_ready;
  assign drop_out  = r_drop;

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Bench for riscv_regfile_mp: two instances (BYPASS=1 and BYPASS=0) share
// every input so bypass and stored-path behaviour are checked side by side.
module tb_riscv_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]        we;
  logic [2*AW-1:0]   wa;
  logic [2*XLEN-1:0] wd;
  logic [2*AW-1:0]   ra;
  logic [AW-1:0]     dbg_addr;
  logic [2*XLEN-1:0] rd_b, rd_n;
  logic [XLEN-1:0]   dbg_b, dbg_n;
  logic              ready_b, ready_n, drop_b, drop_n;

  riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) u_byp (
    .clk_in(clk), .rst_n_in(rst_n), .we_in(we), .wa_in(wa), .wd_in(wd),
    .ra_in(ra), .rd_out(rd_b), .dbg_addr_in(dbg_addr), .dbg_data_out(dbg_b),
    .ready_out(ready_b), .drop_out(drop_b)
  );

  riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) u_nob (
    .clk_in(clk), .rst_n_in(rst_n), .we_in(we), .wa_in(wa), .wd_in(wd),
    .ra_in(ra), .rd_out(rd_n), .dbg_addr_in(dbg_addr), .dbg_data_out(dbg_n),
    .ready_out(ready_n), .drop_out(drop_n)
  );

  // ---------------- scoreboard / model ----------------
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] model [32];
  logic            model_ready;
  logic [XLEN-1:0] obs [6];
  logic [XLEN-1:0] e;
  int              n_checks;
  int              n_fail;

  always_comb begin
    obs[0] = rd_b[31:0];
    obs[1] = rd_b[63:32];
    obs[2] = rd_n[31:0];
    obs[3] = rd_n[63:32];
    obs[4] = dbg_b;
    obs[5] = dbg_n;
  end

  function automatic string pname(int i);
    case (i)
      0: return "byp.rd0";
      1: return "byp.rd1";
      2: return "nob.rd0";
      3: return "nob.rd1";
      4: return "byp.dbg";
      default: return "nob.dbg";
    endcase
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(bit bp, logic [AW-1:0] a);
    if (!model_ready || a == 0) return '0;
    if (bp) begin
      if (we[1] && wa[9:5] == a) return wd[63:32];
      if (we[0] && wa[4:0] == a) return wd[31:0];
    end
    return model[a];
  endfunction

  function automatic logic [XLEN-1:0] exp_dbg(logic [AW-1:0] a);
    if (!model_ready || a == 0) return '0;
    return model[a];
  endfunction

  // Push the six expected observations in obs[] order for current inputs.
  task automatic push_expect();
    exp_q.push_back(exp_rd(1'b1, ra[4:0]));
    exp_q.push_back(exp_rd(1'b1, ra[9:5]));
    exp_q.push_back(exp_rd(1'b0, ra[4:0]));
    exp_q.push_back(exp_rd(1'b0, ra[9:5]));
    exp_q.push_back(exp_dbg(dbg_addr));
    exp_q.push_back(exp_dbg(dbg_addr));
  endtask

  // ---------------- driver tasks ----------------
  task automatic commit();
    if (model_ready) begin
      if (we[0] && wa[4:0] != 0) model[wa[4:0]] = wd[31:0];
      if (we[1] && wa[9:5] != 0) model[wa[9:5]] = wd[63:32];
    end
  endtask

  task automatic step();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic idle_inputs();
    we = 2'b00; wa = '0; wd = '0; ra = '0; dbg_addr = '0;
  endtask

  task automatic model_zero();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_ready = 1'b0;
    repeat (3) step();
    n_checks += 4;
    if (ready_b !== 1'b0) begin n_fail++; $display("FAIL reset.ready_byp got %b exp 0", ready_b); end
    if (ready_n !== 1'b0) begin n_fail++; $display("FAIL reset.ready_nob got %b exp 0", ready_n); end
    if (drop_b !== 1'b0) begin n_fail++; $display("FAIL reset.drop_byp got %b exp 0", drop_b); end
    if (drop_n !== 1'b0) begin n_fail++; $display("FAIL reset.drop_nob got %b exp 0", drop_n); end
    ra = {5'd31, 5'd5}; dbg_addr = 5'd9;
    push_expect();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[i] !== e) begin n_fail++; $display("FAIL reset.%s got %h exp %h", pname(i), obs[i], e); end
    end
    rst_n = 1'b1;
    model_zero();
    for (int k = 1; k <= 31; k++) begin
      step();
      n_checks += 2;
      if (ready_b !== (k == 31)) begin n_fail++; $display("FAIL clear.ready_byp edge %0d got %b exp %b", k, ready_b, k == 31); end
      if (ready_n !== (k == 31)) begin n_fail++; $display("FAIL clear.ready_nob edge %0d got %b exp %b", k, ready_n, k == 31); end
    end
    model_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra = {5'(31 - i), 5'(i)}; dbg_addr = 5'(i);
      push_expect();
      @(negedge clk);
      for (int j = 0; j < 6; j++) begin
        e = exp_q.pop_front(); n_checks++;
        if (obs[j] !== e) begin n_fail++; $display("FAIL sweep.%s x%0d got %h exp %h", pname(j), i, obs[j], e); end
      end
      step();
    end
  endtask

  task automatic test_basic();
    idle_inputs();
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF}; ra = {5'd0, 5'd5};
    step();
    we = 2'b00; dbg_addr = 5'd5;
    push_expect();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[i] !== e) begin n_fail++; $display("FAIL basic.%s got %h exp %h", pname(i), obs[i], e); end
    end
    n_checks += 2;
    if (drop_b !== 1'b0) begin n_fail++; $display("FAIL basic.drop_byp got %b exp 0", drop_b); end
    if (drop_n !== 1'b0) begin n_fail++; $display("FAIL basic.drop_nob got %b exp 0", drop_n); end
    // x0 write while reading x0 on both ports: never bypassed, never stored
    we = 2'b01; wa = '0; wd = {32'h0, 32'h1234}; ra = '0; dbg_addr = '0;
    push_expect();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[i] !== e) begin n_fail++; $display("FAIL x0_during.%s got %h exp %h", pname(i), obs[i], e); end
    end
    step();
    we = 2'b00;
    push_expect();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[i] !== e) begin n_fail++; $display("FAIL x0_after.%s got %h exp %h", pname(i), obs[i], e); end
    end
    step();
  endtask

  task automatic test_dual_write();
    idle_inputs();
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h5555FFFF, 32'hAAAA0000};
    ra = {5'd7, 5'd7}; dbg_addr = 5'd7;
    push_expect();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[i] !== e) begin n_fail++; $display("FAIL dual_during.%s got %h exp %h", pname(i), obs[i], e); end
    end
    step();
    we = 2'b00;
    push_expect();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[i] !== e) begin n_fail++; $display("FAIL dual_after.%s got %h exp %h", pname(i), obs[i], e); end
    end
    step();
  endtask

  task automatic test_bypass();
    idle_inputs();
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h11};
    step();
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h42};
    ra = {5'd1, 5'd3}; dbg_addr = 5'd3;
    push_expect();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[i] !== e) begin n_fail++; $display("FAIL bypass_during.%s got %h exp %h", pname(i), obs[i], e); end
    end
    step();
    we = 2'b00;
    push_expect();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[i] !== e) begin n_fail++; $display("FAIL bypass_after.%s got %h exp %h", pname(i), obs[i], e); end
    end
    step();
  endtask

  task automatic test_write_during_clear();
    idle_inputs();
    rst_n = 1'b0;
    step();
    model_ready = 1'b0;
    rst_n = 1'b1;
    model_zero();
    for (int k = 1; k <= 31; k++) begin
      if (k == 10) begin
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'hFF};
      end else if (k == 12) begin
        we = 2'b01; wa = '0; wd = {32'h0, 32'h1234};
      end else if (k == 31) begin
        // Write on the very edge ready rises: still CLEAR, so dropped.
        we = 2'b10; wa = {5'd4, 5'd0}; wd = {32'h77, 32'h0};
      end else begin
        we = 2'b00;
      end
      step();
      n_checks += 4;
      if (drop_b !== (k == 10 || k == 31)) begin n_fail++; $display("FAIL wclear.drop_byp edge %0d got %b exp %b", k, drop_b, k == 10 || k == 31); end
      if (drop_n !== (k == 10 || k == 31)) begin n_fail++; $display("FAIL wclear.drop_nob edge %0d got %b exp %b", k, drop_n, k == 10 || k == 31); end
      if (ready_b !== (k == 31)) begin n_fail++; $display("FAIL wclear.ready_byp edge %0d got %b exp %b", k, ready_b, k == 31); end
      if (ready_n !== (k == 31)) begin n_fail++; $display("FAIL wclear.ready_nob edge %0d got %b exp %b", k, ready_n, k == 31); end
    end
    model_ready = 1'b1;
    idle_inputs();
    ra = {5'd4, 5'd9}; dbg_addr = 5'd9;
    push_expect();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[i] !== e) begin n_fail++; $display("FAIL wclear_read.%s got %h exp %h", pname(i), obs[i], e); end
    end
    step();
    n_checks += 2;
    if (drop_b !== 1'b0) begin n_fail++; $display("FAIL wclear.drop_byp_end got %b exp 0", drop_b); end
    if (drop_n !== 1'b0) begin n_fail++; $display("FAIL wclear.drop_nob_end got %b exp 0", drop_n); end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 60; it++) begin
      we = 2'($urandom_range(0, 3));
      wa = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wd = {$urandom, $urandom};
      ra = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      dbg_addr = 5'($urandom_range(0, 31));
      push_expect();
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        e = exp_q.pop_front(); n_checks++;
        if (obs[i] !== e) begin n_fail++; $display("FAIL b2b.%s iter %0d got %h exp %h", pname(i), it, obs[i], e); end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    idle_inputs();
    for (int i = 1; i < 32; i++) begin
      we = 2'b01; wa = {5'd0, 5'(i)}; wd = {32'h0, $urandom | 32'h1};
      step();
    end
    we = 2'b00; ra = {5'd31, 5'd1}; dbg_addr = 5'd17;
    push_expect();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[i] !== e) begin n_fail++; $display("FAIL loaded.%s got %h exp %h", pname(i), obs[i], e); end
    end
    rst_n = 1'b0;
    step();
    model_ready = 1'b0;
    rst_n = 1'b1;
    n_checks += 2;
    if (ready_b !== 1'b0) begin n_fail++; $display("FAIL midrst.ready_byp got %b exp 0", ready_b); end
    if (ready_n !== 1'b0) begin n_fail++; $display("FAIL midrst.ready_nob got %b exp 0", ready_n); end
    push_expect();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[i] !== e) begin n_fail++; $display("FAIL midrst.%s got %h exp %h", pname(i), obs[i], e); end
    end
    model_zero();
    for (int k = 1; k <= 31; k++) begin
      step();
      n_checks += 2;
      if (ready_b !== (k == 31)) begin n_fail++; $display("FAIL reclear.ready_byp edge %0d got %b exp %b", k, ready_b, k == 31); end
      if (ready_n !== (k == 31)) begin n_fail++; $display("FAIL reclear.ready_nob edge %0d got %b exp %b", k, ready_n, k == 31); end
    end
    model_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra = {5'(31 - i), 5'(i)}; dbg_addr = 5'(i);
      push_expect();
      @(negedge clk);
      for (int j = 0; j < 6; j++) begin
        e = exp_q.pop_front(); n_checks++;
        if (obs[j] !== e) begin n_fail++; $display("FAIL resweep.%s x%0d got %h exp %h", pname(j), i, obs[j], e); end
      end
      step();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    model_ready = 1'b0;
    model_zero();
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_dual_write();
    test_bypass();
    test_write_during_clear();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/riscv_regfile_mp.md
# riscv_regfile_mp

Parametrised multi-ported integer register file for the RISC-V core. It has NREAD combinational read ports, two write ports with fixed priority, and optional same-cycle write-to-read bypass. It also has a sequential clear engine that zeroes the array one entry per cycle after reset and raises `ready_out` when done. It sits between decode (read addresses) and writeback (two retire lanes), with a debug read port for the on-board monitor.

## Interface
Parameters:
- `XLEN`, default 32: register width in bits.
- `NREGS`, default 32: number of architectural registers; power of two, ≥ 4. `AW = $clog2(NREGS)`.
- `NREAD`, default 2: number of read ports, 1–4.
- `BYPASS`, default 1: when 1, reads return same-cycle write data. When 0, reads return stored data only.

Ports:
- `clk_in`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n_in`, input, 1: reset, synchronous and active-low.
- `we_in`, input, 2: write enable, one bit per write port; port 1 has priority.
- `wa_in`, input, 2*AW: write addresses; port p occupies bits [p*AW +: AW].
- `wd_in`, input, 2*XLEN: write data; port p occupies bits [p*XLEN +: XLEN].
- `ra_in`, input, NREAD*AW: read addresses; port r occupies bits [r*AW +: AW].
- `rd_out`, output, NREAD*XLEN: read data; port r occupies bits [r*XLEN +: XLEN]. Combinational.
- `dbg_addr_in`, input, AW: debug read address.
- `dbg_data_out`, output, XLEN: debug read data. Combinational; never bypassed.
- `ready_out`, output, 1: high once the clear sequence has finished; writes are accepted only while high.
- `drop_out`, output, 1: registered pulse, high for one cycle after any enabled write was ignored because `ready_out` was 0.

## Operation
- Storage is NREGS × XLEN. Entry 0 is hardwired: every read of address 0 returns 0 on all ports including debug, and writes to address 0 are discarded.
- The clear FSM has two states, CLEAR and READY, and an AW-bit pointer `ptr`.
  - On any edge with `rst_n_in`=0: state ← CLEAR, `ptr` ← 1, `ready_out` ← 0, `drop_out` ← 0. Array contents are not touched on that edge.
  - CLEAR, `rst_n_in`=1: entry[`ptr`] ← 0. If `ptr` == NREGS−1, state ← READY and `ready_out` ← 1; otherwise `ptr` ← `ptr`+1.
  - READY: stays in READY until the next reset.
- Writes while READY:
  - For each port p with `we_in[p]`=1 and a nonzero address, entry[`wa_in[p]`] ← `wd_in[p]`.
  - If both ports target the same nonzero address, port 1's data is stored.
- Writes while CLEAR: all writes are ignored. `drop_out` is set for one cycle if any `we_in` bit was 1 with a nonzero address.
- Reads while CLEAR: every read port and the debug port return 0.
- Reads while READY:
  - `rd_out[r]` = entry[`ra_in[r]`].
  - If BYPASS=1 and an enabled write in the same cycle hits the same nonzero address, `rd_out[r]` returns that write's data. When both write ports hit it, port 1's data is returned.
- Address arithmetic is unsigned AW-bit; no out-of-range addresses exist.

## Timing
- Read latency: 0 cycles, combinational from `ra_in`, `we_in`, `wa_in` and `wd_in`.
- Write latency: data is visible through the stored path on the cycle after the write edge. With BYPASS=1 it is also visible in the same cycle.
- Clear duration: `ready_out` rises at the (NREGS−1)th rising edge with `rst_n_in`=1 after reset is released. For NREGS=32 that is edge 31.
- Reset during CLEAR restarts the sequence at `ptr`=1.
- Reset during READY drops `ready_out` on that edge and begins a full clear.
- A write on the same edge that `ready_out` rises is dropped; the state was still CLEAR on that edge.
- Reset values: `ready_out`=0, `drop_out`=0; `rd_out` and `dbg_data_out` = 0, because the state is CLEAR.

## Test plan
- Reset release, NREGS=32: hold `rst_n_in`=0 for 3 cycles, then release. Required: `ready_out`=0 for exactly 30 edges and 1 after edge 31; every entry then reads 0.
- Basic write/read: write 0xDEADBEEF to x5 on port 0. Required: next cycle `ra_in[0]`=5 returns 0xDEADBEEF. Writing 0x1234 to x0 leaves `rd_out` for address 0 at 0.
- Dual-write conflict: port 0 writes 0xAAAA0000 and port 1 writes 0x5555FFFF to x7 on the same edge. Required: x7 reads 0x5555FFFF afterwards, and, with BYPASS=1, during the write cycle.
- Bypass on/off: write 0x42 to x3 while reading x3, x3 holding 0x11. Required: BYPASS=1 reads 0x42 in that cycle; BYPASS=0 reads 0x11, then 0x42 on the next cycle. `dbg_data_out` shows 0x11 in that cycle under both settings.
- Write during clear: at edge 10 after release, assert `we_in`=01 with x9=0xFF. Required: `drop_out`=1 for one cycle and x9 reads 0 after ready. A write to x0 during CLEAR does not set `drop_out`.
- Reset mid-operation: load x1–x31 with nonzero data, then assert `rst_n_in`=0 for 1 cycle during READY. Required: `ready_out` falls on that edge, all reads return 0 immediately, and `ready_out` rises again 31 edges after release with all entries 0.
